// File: rtl/fft2d_stream.sv
// Streaming N x N 2D FFT/IFFT: registered row DFT -> ping-pong transpose buffer -> registered column DFT.
// Twiddles are limited to +-1/+-j (N = 2 or 4), so every stage is exact add/subtract.
module fft2d_stream #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned SCALE = 0,
    localparam int unsigned L    = (N == 4) ? 2 : 1,
    localparam int unsigned RW   = (SCALE != 0) ? W : W + L,
    localparam int unsigned OW   = (SCALE != 0) ? W : W + 2 * L
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              next_i,
    input  logic              inverse_i,
    input  logic [N*2*W-1:0]  in_i,
    output logic [N*2*OW-1:0] out_o,
    output logic              next_out_o,
    output logic              err_o
);
    localparam int unsigned XW   = W + 2 * L + 1;
    localparam logic [L-1:0] LAST = L'(N - 1);

    // Input window tracking
    logic             win_q, win_d;
    logic [L-1:0]     row_cnt_q, row_cnt_d;
    logic             frame_inv_q, frame_inv_d;
    // Row stage register
    logic             rs_vld_q, rs_vld_d;
    logic [L-1:0]     rs_row_q, rs_row_d;
    logic             rs_inv_q, rs_inv_d;
    logic [N*2*RW-1:0] rs_q, rs_d;
    // Transpose buffer and column reader
    logic [N*2*RW-1:0] bank_q [2][N];
    logic             wbank_q, wbank_d;
    logic             rd_act_q, rd_act_d;
    logic             rd_bank_q, rd_bank_d;
    logic [L-1:0]     rd_col_q, rd_col_d;
    logic             rd_inv_q, rd_inv_d;
    // Outputs
    logic [N*2*OW-1:0] out_q, out_d;
    logic             next_out_q, next_out_d;
    logic             err_q, err_d;

    logic [N*2*XW-1:0] row_x_c, row_y_c, col_x_c, col_y_c;
    logic             last_row_c, wr_last_c;

    // N-point DFT on sign-extended lanes; inverse conjugates the quarter-turn twiddle
    function automatic logic [N*2*XW-1:0] dft(input logic [N*2*XW-1:0] x, input logic inv);
        logic signed [XW-1:0] acc_re, acc_im, xr, xi;
        logic [1:0]           q;
        logic [N*2*XW-1:0]    y;
        y = '0;
        for (int k = 0; k < N; k++) begin
            acc_re = '0;
            acc_im = '0;
            for (int n = 0; n < N; n++) begin
                xr = signed'(x[2*XW*n + XW +: XW]);
                xi = signed'(x[2*XW*n +: XW]);
                q  = 2'(((k * n) % N) * (4 / N));
                if (inv) q = 2'd0 - q;
                case (q)
                    2'd0:    begin acc_re = acc_re + xr; acc_im = acc_im + xi; end
                    2'd1:    begin acc_re = acc_re + xi; acc_im = acc_im - xr; end
                    2'd2:    begin acc_re = acc_re - xr; acc_im = acc_im - xi; end
                    default: begin acc_re = acc_re - xi; acc_im = acc_im + xr; end
                endcase
            end
            if (SCALE != 0) begin
                acc_re = acc_re >>> L;
                acc_im = acc_im >>> L;
            end
            y[2*XW*k + XW +: XW] = acc_re;
            y[2*XW*k +: XW]      = acc_im;
        end
        return y;
    endfunction

    // Widen the incoming row and the column being drained, then transform both
    always_comb begin : stage_in
        logic [2*RW-1:0] cw;
        cw      = '0;
        row_x_c = '0;
        col_x_c = '0;
        for (int n = 0; n < N; n++) begin
            row_x_c[2*XW*n + XW +: XW] = XW'(signed'(in_i[2*W*n + W +: W]));
            row_x_c[2*XW*n +: XW]      = XW'(signed'(in_i[2*W*n +: W]));
            cw = bank_q[rd_bank_q][n][2*RW*32'(rd_col_q) +: 2*RW];
            col_x_c[2*XW*n + XW +: XW] = XW'(signed'(cw[RW +: RW]));
            col_x_c[2*XW*n +: XW]      = XW'(signed'(cw[0 +: RW]));
        end
        row_y_c = dft(row_x_c, frame_inv_q);
        col_y_c = dft(col_x_c, rd_inv_q);
    end

    always_comb begin : next_state
        win_d       = win_q;
        row_cnt_d   = row_cnt_q;
        frame_inv_d = frame_inv_q;
        err_d       = 1'b0;
        last_row_c  = win_q && (row_cnt_q == LAST);
        if (win_q) begin
            row_cnt_d = row_cnt_q + L'(1);
            if (last_row_c) win_d = 1'b0;
        end
        // A new frame may start only when idle or on the last row of the current one
        if (next_i) begin
            if (!win_q || last_row_c) begin
                win_d       = 1'b1;
                row_cnt_d   = '0;
                frame_inv_d = inverse_i;
            end else begin
                err_d = 1'b1;
            end
        end

        rs_vld_d = win_q;
        rs_row_d = row_cnt_q;
        rs_inv_d = frame_inv_q;
        rs_d     = rs_q;
        if (win_q) begin
            for (int k = 0; k < N; k++) begin
                rs_d[2*RW*k + RW +: RW] = RW'(row_y_c[2*XW*k + XW +: XW]);
                rs_d[2*RW*k +: RW]      = RW'(row_y_c[2*XW*k +: XW]);
            end
        end

        wr_last_c  = rs_vld_q && (rs_row_q == LAST);
        wbank_d    = wbank_q ^ wr_last_c;
        next_out_d = wr_last_c;

        rd_act_d  = rd_act_q;
        rd_col_d  = rd_col_q;
        rd_bank_d = rd_bank_q;
        rd_inv_d  = rd_inv_q;
        if (rd_act_q) begin
            rd_col_d = rd_col_q + L'(1);
            if (rd_col_q == LAST) rd_act_d = 1'b0;
        end
        // A freshly completed bank takes over the reader on the same edge the old drain ends
        if (wr_last_c) begin
            rd_act_d  = 1'b1;
            rd_col_d  = '0;
            rd_bank_d = wbank_q;
            rd_inv_d  = rs_inv_q;
        end

        out_d = out_q;
        if (rd_act_q) begin
            for (int k = 0; k < N; k++) begin
                out_d[2*OW*k + OW +: OW] = OW'(col_y_c[2*XW*k + XW +: XW]);
                out_d[2*OW*k +: OW]      = OW'(col_y_c[2*XW*k +: XW]);
            end
        end
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            win_q       <= 1'b0;
            row_cnt_q   <= '0;
            frame_inv_q <= 1'b0;
            rs_vld_q    <= 1'b0;
            rs_row_q    <= '0;
            rs_inv_q    <= 1'b0;
            rs_q        <= '0;
            wbank_q     <= 1'b0;
            rd_act_q    <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_col_q    <= '0;
            rd_inv_q    <= 1'b0;
            out_q       <= '0;
            next_out_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            win_q       <= win_d;
            row_cnt_q   <= row_cnt_d;
            frame_inv_q <= frame_inv_d;
            rs_vld_q    <= rs_vld_d;
            rs_row_q    <= rs_row_d;
            rs_inv_q    <= rs_inv_d;
            rs_q        <= rs_d;
            wbank_q     <= wbank_d;
            rd_act_q    <= rd_act_d;
            rd_bank_q   <= rd_bank_d;
            rd_col_q    <= rd_col_d;
            rd_inv_q    <= rd_inv_d;
            out_q       <= out_d;
            next_out_q  <= next_out_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin : bank_wr
        if (!reset && rs_vld_q) bank_q[wbank_q][rs_row_q] <= rs_q;
    end

    assign out_o      = out_q;
    assign next_out_o = next_out_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_fft2d_stream.sv
// Scoreboard bench for fft2d_stream: unscaled (OW=20) and scaled (OW=16) instances share stimulus.
module tb_fft2d_stream;
    localparam int K_IMP   = 0;
    localparam int K_CONST = 1;
    localparam int K_TONE  = 2;
    localparam int K_NEG   = 3;

    logic         clk = 1'b0;
    logic         reset, next_i, inverse_i;
    logic [127:0] in_i;
    logic [159:0] out_o;
    logic         next_out_o, err_o;
    logic [127:0] outs_o;
    logic         next_outs_o, errs_o;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int unsigned       nxt;
        logic [3:0][159:0] row;
        logic [3:0][127:0] srow;
    } exp_t;

    exp_t        sb[$];
    int unsigned err_exp[$];

    fft2d_stream #(.N(4), .W(16), .SCALE(0)) dut (
        .clk(clk), .reset(reset), .next_i(next_i), .inverse_i(inverse_i), .in_i(in_i),
        .out_o(out_o), .next_out_o(next_out_o), .err_o(err_o)
    );
    fft2d_stream #(.N(4), .W(16), .SCALE(1)) dut_s (
        .clk(clk), .reset(reset), .next_i(next_i), .inverse_i(inverse_i), .in_i(in_i),
        .out_o(outs_o), .next_out_o(next_outs_o), .err_o(errs_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Input row m of each directed frame
    function automatic logic [127:0] row_of(input int kind, input int m);
        logic [127:0] r;
        int re, im;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            re = 0; im = 0;
            case (kind)
                K_IMP:   if (m == 0 && n == 0) re = 1;
                K_CONST: re = 1;
                K_TONE:  case (n)
                             0: re = 1;
                             1: im = 1;
                             2: re = -1;
                             default: im = -1;
                         endcase
                default: if (m == 0 && n == 0) re = -1;
            endcase
            r[32*n +: 32] = {16'(re), 16'(im)};
        end
        return r;
    endfunction

    // Hand-derived X[u][v] (real part; all imaginary parts are 0) unscaled and scaled
    function automatic void exp_elem(input int kind, input logic inv, input int u, input int v,
                                     output int re, output int sre);
        re = 0; sre = 0;
        case (kind)
            K_IMP:   begin re = 1; sre = 0; end
            K_CONST: if (u == 0 && v == 0) begin re = 16; sre = 1; end
            K_TONE:  if (u == 0 && v == (inv ? 3 : 1)) begin re = 16; sre = 1; end
            default: begin re = -1; sre = -1; end
        endcase
    endfunction

    function automatic logic [159:0] exp_row(input int kind, input logic inv, input int v);
        logic [159:0] r;
        int re, sre;
        r = '0;
        for (int u = 0; u < 4; u++) begin
            exp_elem(kind, inv, u, v, re, sre);
            r[40*u +: 40] = {20'(re), 20'd0};
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_srow(input int kind, input logic inv, input int v);
        logic [127:0] r;
        int re, sre;
        r = '0;
        for (int u = 0; u < 4; u++) begin
            exp_elem(kind, inv, u, v, re, sre);
            r[32*u +: 32] = {16'(sre), 16'd0};
        end
        return r;
    endfunction

    task automatic issue_next(input int kind, input logic inv);
        exp_t e;
        next_i    = 1'b1;
        inverse_i = inv;
        e.nxt     = cyc + 6;
        for (int v = 0; v < 4; v++) begin
            e.row[v]  = exp_row(kind, inv, v);
            e.srow[v] = exp_srow(kind, inv, v);
        end
        sb.push_back(e);
    endtask

    // cnt contiguous frames, each next coinciding with the previous frame's last row
    task automatic send_seq(input int cnt, input int k0, input int k1, input int k2,
                            input logic i0, input logic i1, input logic i2);
        int   ks[3];
        logic iv[3];
        ks[0] = k0; ks[1] = k1; ks[2] = k2;
        iv[0] = i0; iv[1] = i1; iv[2] = i2;
        @(negedge clk);
        issue_next(ks[0], iv[0]);
        for (int f = 0; f < cnt; f++) begin
            for (int m = 0; m < 4; m++) begin
                @(negedge clk);
                next_i = 1'b0;
                in_i   = row_of(ks[f], m);
                if (m == 3 && f + 1 < cnt) issue_next(ks[f+1], iv[f+1]);
            end
        end
        @(negedge clk);
        next_i = 1'b0;
        in_i   = '0;
    endtask

    task automatic idle(input int n);
        next_i = 1'b0;
        in_i   = '0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops an expected frame on each next_out and checks the following four rows
    int   rows_left = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (reset) begin
            rows_left = 0;
        end else begin
            if (rows_left > 0) begin
                chk("out_row", out_o, cur.row[4-rows_left]);
                chk("outs_row", 160'(outs_o), 160'(cur.srow[4-rows_left]));
                rows_left--;
            end
            if (next_out_o) begin
                if (sb.size() == 0) begin
                    chk("next_out_unexpected", 160'(next_out_o), 160'(0));
                end else begin
                    cur = sb.pop_front();
                    chk("next_out_cyc", 160'(cyc), 160'(cur.nxt));
                    chk("next_out_scaled", 160'(next_outs_o), 160'(1));
                    rows_left = 4;
                end
            end
            if (err_o) begin
                if (err_exp.size() == 0) chk("err_unexpected", 160'(err_o), 160'(0));
                else chk("err_cyc", 160'(cyc), 160'(err_exp.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; next_i = 1'b0; inverse_i = 1'b0; in_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", out_o, 160'(0));
        chk("rst_outs", 160'(outs_o), 160'(0));
        chk("rst_next_out", 160'(next_out_o), 160'(0));
        chk("rst_err", 160'(err_o), 160'(0));
        reset = 1'b0;

        send_seq(1, K_IMP, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(12);
        chk("out_hold", out_o, exp_row(K_IMP, 1'b0, 3));
        send_seq(1, K_CONST, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(12);
        send_seq(1, K_TONE, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(12);
        send_seq(1, K_TONE, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(12);
        send_seq(1, K_NEG, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(12);

        send_seq(3, K_IMP, K_CONST, K_TONE, 1'b0, 1'b0, 1'b0);
        idle(14);
        send_seq(3, K_TONE, K_TONE, K_NEG, 1'b0, 1'b1, 1'b0);
        idle(14);

        // Violating next on the second row, with inverse set, must be ignored
        @(negedge clk); issue_next(K_TONE, 1'b0);
        @(negedge clk); next_i = 1'b0; in_i = row_of(K_TONE, 0);
        @(negedge clk); next_i = 1'b1; inverse_i = 1'b1; in_i = row_of(K_TONE, 1);
        err_exp.push_back(cyc + 1);
        @(negedge clk); next_i = 1'b0; inverse_i = 1'b0; in_i = row_of(K_TONE, 2);
        @(negedge clk); in_i = row_of(K_TONE, 3);
        @(negedge clk); in_i = '0;
        idle(12);

        // Leave a nonzero held output, then abort a frame with a one-cycle reset
        send_seq(1, K_NEG, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(12);
        @(negedge clk); issue_next(K_CONST, 1'b0);
        @(negedge clk); next_i = 1'b0; in_i = row_of(K_CONST, 0);
        @(negedge clk); in_i = row_of(K_CONST, 1);
        @(negedge clk); reset = 1'b1; in_i = row_of(K_CONST, 2); sb.delete();
        @(negedge clk); reset = 1'b0; in_i = '0;
        chk("rst_mid_out", out_o, 160'(0));
        chk("rst_mid_outs", 160'(outs_o), 160'(0));
        chk("rst_mid_next_out", 160'(next_out_o), 160'(0));
        chk("rst_mid_err", 160'(err_o), 160'(0));
        @(negedge clk); issue_next(K_IMP, 1'b0);
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            next_i = 1'b0;
            in_i   = row_of(K_IMP, m);
        end
        @(negedge clk); in_i = '0;
        idle(16);

        chk("sb_drain", 160'(sb.size()), 160'(0));
        chk("err_drain", 160'(err_exp.size()), 160'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft2d_stream.md
Name: fft2d_stream

Overview:
- Streaming N x N 2D FFT (or IFFT). Input arrives one row per cycle. Registered row DFT stage feeds a ping-pong transpose buffer, which feeds a registered column DFT stage.
- Uses the frame-start pulse protocol of the existing FFT cores (`next` in, `next_out` out).
- Generalises the fixed 4x4 array: lane count, sample width, inverse mode and per-stage scaling are all parametrised, and back-to-back frames are sustained.

Parameters:
- N, 4, points per dimension; legal values 2 or 4 (twiddles ±1, ±j only, so arithmetic is exact).
- W, 16, signed width of each real and imaginary input component.
- SCALE, 0, 1 = arithmetic shift right by log2(N) after each stage (floor); 0 = full bit growth.
- OW, derived: W if SCALE=1, else W+2*log2(N). Signed output component width.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- next, in, 1, one-cycle pulse one cycle before the first input row of a frame.
- inverse, in, 1, sampled with next; 1 = conjugate twiddles (unnormalised IFFT); held per frame.
- in, in, N*2*W, one row. Lane k at [2W*k +: 2W]; real in the upper W bits, imaginary in the lower W bits.
- out, out, N*2*OW, one output row, packed the same way with OW-bit components.
- next_out, out, 1, one-cycle pulse one cycle before the first output row of a frame.
- err, out, 1, one-cycle pulse on a protocol violation.

Behaviour:
- Reset: next_out=0, err=0, out=0. Frame/row counters, bank pointers and in-flight frames are cleared; partial frames are discarded with no output.
- Input window: next at cycle t0. Rows m=0..N-1 are sampled on cycles t0+1..t0+N. `in` is ignored outside an active window.
- Transform: X[u][v] = sum over m,n of x[m][n]·W^(um+vn), with W = e^(-2πj/N), or e^(+2πj/N) when the frame's inverse=1. Here m is the input row (cycle) and n is the lane.
- Output order is transposed: output cycle v, lane u carries X[u][v].
- Latency: next_out is asserted at t0+N+2. Output rows v=0..N-1 appear on cycles t0+N+3..t0+2N+2. `out` holds its last value between frames.
- Row stage: combinational N-point DFT on the current input row, registered.
  - Result width is W+log2(N) (SCALE=0), or W after the shift (SCALE=1).
  - Written as row m of the current write bank.
- Transpose buffer: two banks of N x N complex words.
  - Write fills rows. Read drains columns, column v feeds the column stage in parallel (lane m = R[m][v]).
  - Read of a bank starts the cycle after its last row is written.
  - Bank pointer toggles per accepted frame.
- Column stage: N-point DFT, registered, with the same growth/scaling rule as the row stage.
- Back-to-back: next may be asserted at t0+N, giving contiguous rows. Throughput is one frame per N cycles, indefinitely, with no bubbles.
- Each frame's inverse flag travels with that frame's bank. Mixing forward and inverse frames back-to-back is legal.
- Violation: next asserted on cycles t0+1..t0+N-1 of an active input window.
  - That next is ignored and err pulses the same cycle +1.
  - The current frame continues unaffected.
- No overflow is possible: the SCALE=0 widths cover full growth. SCALE=1 results are floor-shifted, i.e. two's-complement truncation.
- Reset mid-frame: asserting reset during input or output suppresses any remaining next_out and output rows of that frame. A next on the first cycle after reset deassertion starts a fresh frame.

Test Plan:
- Impulse: N=4, W=16, SCALE=0. x[0][0]=1+0j, all other samples 0. Expect next_out at t0+6, then 4 rows with every lane = 1+0j on cycles t0+7..t0+10.
- Constant: all x=1+0j, SCALE=0 gives X[0][0]=16 and all else 0 (OW=20). With SCALE=1: X[0][0]=1 and all else 0.
- Tone / inverse:
  - x[m][n]=j^n (N=4), forward transform: X[0][1]=16, all else 0.
  - Same input with inverse=1: X[0][3]=16, all else 0.
- Back-to-back: three frames (impulse, constant, tone) with next at t0, t0+4, t0+8. Expect three next_out pulses spaced 4 cycles apart, correct outputs for each frame, and no err.
- Violation: next at t0, then again at t0+2. Expect err pulse at t0+3, a single next_out at t0+6, and frame output unchanged.
- Reset mid-frame: reset at t0+3 for one cycle, next at t0+5 with an impulse frame. Expect no output for the aborted frame, next_out at t0+11, all-ones output rows after it, and all outputs 0 during reset.
